// File: rtl/equiv_check_sequencer.sv
// Lockstep equivalence-check sequencer: drives one LFSR vector to two UUTs,
// waits SETTLE_CYCLES, compares their outputs, and tracks mismatches.
//
// Ports:
//   clk, rst (sync, active-high), start
//   stim_out      : vector broadcast to both UUTs
//   beh_out       : Behavioral UUT outputs
//   str_out       : Structural UUT outputs
//   busy, done, pass, mismatch_pulse : run status
//   vec_count, mismatch_count        : progress counters
//   first_fail_vec, first_fail_stim  : first failing vector of the run
module equiv_check_sequencer #(
  parameter int          IN_W          = 4,
  parameter int          OUT_W         = 2,
  parameter int          N_VECTORS     = 10,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  stim_out,
  input  logic [OUT_W-1:0] beh_out,
  input  logic [OUT_W-1:0] str_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch_pulse,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] first_fail_vec,
  output logic [IN_W-1:0]  first_fail_stim
);

  // An all-zero seed would lock the LFSR up.
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  // Wide enough to hold SETTLE_CYCLES itself after the last increment.
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_VECTORS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_nxt;
  logic [SW-1:0]    r_settle;
  logic             r_seen;
  logic [IN_W-1:0]  r_stim;
  logic [CNT_W-1:0] r_vec;
  logic [CNT_W-1:0] r_mis;
  logic [CNT_W-1:0] r_ffv;
  logic [IN_W-1:0]  r_ffs;
  logic             r_pulse;
  logic [CNT_W-1:0] w_vec_inc;
  logic             w_mismatch;

  // Galois, right shift, taps 0xB400.
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]}
                    ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_vec_inc  = r_vec + CNT_W'(1);
  assign w_mismatch = (beh_out != str_out);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        busy   = 1'b1;
        w_next = S_APPLY;
      end
      S_APPLY: begin
        busy   = 1'b1;
        w_next = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (r_settle == SETTLE_LAST) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        busy   = 1'b1;
        w_next = (w_vec_inc == N_LAST) ? S_DONE : S_APPLY;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr   <= SEED;
      r_settle <= '0;
      r_seen   <= 1'b0;
      r_stim   <= '0;
      r_vec    <= '0;
      r_mis    <= '0;
      r_ffv    <= '0;
      r_ffs    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          r_lfsr <= SEED;
          r_seen <= 1'b0;
          r_vec  <= '0;
          r_mis  <= '0;
          r_ffv  <= '0;
          r_ffs  <= '0;
        end
        S_APPLY: begin
          r_stim   <= r_lfsr[IN_W-1:0];
          r_lfsr   <= w_lfsr_nxt;
          r_settle <= '0;
        end
        S_SETTLE: begin
          r_settle <= r_settle + SW'(1);
        end
        S_COMPARE: begin
          r_vec <= w_vec_inc;
          if (w_mismatch) begin
            r_mis   <= r_mis + CNT_W'(1);
            r_pulse <= 1'b1;
            if (!r_seen) begin
              r_seen <= 1'b1;
              r_ffv  <= r_vec;
              r_ffs  <= r_stim;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign stim_out        = r_stim;
  assign mismatch_pulse  = r_pulse;
  assign vec_count       = r_vec;
  assign mismatch_count  = r_mis;
  assign first_fail_vec  = r_ffv;
  assign first_fail_stim = r_ffs;
  assign pass            = done && (r_mis == '0);

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Directed bench for equiv_check_sequencer: default instance plus a
// SETTLE_CYCLES=1, N_VECTORS=1 instance.
module tb_equiv_check_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start1;
  int         mode;

  logic [3:0] stim;
  logic [1:0] beh;
  logic [1:0] str;
  logic       busy, done, pass, mpulse;
  logic [7:0] vcnt, mcnt, ffv;
  logic [3:0] ffs;

  logic [3:0] stim1;
  logic [1:0] beh1;
  logic [1:0] str1;
  logic       busy1, done1, pass1, mpulse1;
  logic [7:0] vcnt1, mcnt1, ffv1;
  logic [3:0] ffs1;

  int         n_chk = 0;
  int         n_fail = 0;
  int         edges;
  int         pulses;
  logic [3:0] seq [10];
  logic [3:0] exp_seq [10];

  always #5 clk = ~clk;

  assign beh = stim[1:0];
  assign str = (mode == 1) ? (beh ^ 2'b01) :
               ((mode == 2) && (stim == 4'hC)) ? (beh ^ 2'b10) : beh;
  assign beh1 = stim1[1:0];
  assign str1 = stim1[1:0];

  equiv_check_sequencer u_dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stim_out        (stim),
    .beh_out         (beh),
    .str_out         (str),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .mismatch_pulse  (mpulse),
    .vec_count       (vcnt),
    .mismatch_count  (mcnt),
    .first_fail_vec  (ffv),
    .first_fail_stim (ffs)
  );

  equiv_check_sequencer #(
    .SETTLE_CYCLES (1),
    .N_VECTORS     (1)
  ) u_dut1 (
    .clk             (clk),
    .rst             (rst),
    .start           (start1),
    .stim_out        (stim1),
    .beh_out         (beh1),
    .str_out         (str1),
    .busy            (busy1),
    .done            (done1),
    .pass            (pass1),
    .mismatch_pulse  (mpulse1),
    .vec_count       (vcnt1),
    .mismatch_count  (mcnt1),
    .first_fail_vec  (ffv1),
    .first_fail_stim (ffs1)
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // edges counts clock edges after the one that samples start.
  task automatic run(input bit repulse, input int stop_at);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    edges  = 0;
    pulses = 0;
    while (done !== 1'b1 && edges < 200 &&
           (stop_at == 0 || edges < stop_at)) begin
      @(negedge clk);
      edges++;
      start = repulse && (edges == 9 || edges == 19);
      if (mpulse === 1'b1) pulses++;
      if (edges >= 2 && (edges - 2) % 4 == 0 && (edges - 2) / 4 < 10)
        seq[(edges - 2) / 4] = stim;
    end
  endtask

  task automatic chk_seq(input string tag);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(seq[i]), 32'(exp_seq[i]));
  endtask

  initial begin
    int e;
    logic [3:0] s_pre, s_a, s_b;
    exp_seq = '{4'h1, 4'h0, 4'h8, 4'hC, 4'hE,
                4'h7, 4'h3, 4'h9, 4'h4, 4'h2};
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_flags", 32'({busy, done, pass, mpulse}), 32'h0);
    chk("rst_cnt", 32'({vcnt, mcnt, ffv}), 32'h0);
    chk("rst_stim", 32'({ffs, stim}), 32'h0);
    chk("rst_flags1", 32'({busy1, done1, pass1, mpulse1}), 32'h0);

    // Matching UUTs
    mode = 0;
    run(1'b0, 0);
    chk("m0_latency", edges, 41);
    chk_seq("m0_stim");
    chk("m0_pass", 32'(pass), 32'h1);
    chk("m0_busy", 32'(busy), 32'h0);
    chk("m0_vcnt", 32'(vcnt), 32'd10);
    chk("m0_mcnt", 32'(mcnt), 32'd0);
    chk("m0_pulses", pulses, 0);

    // Every vector mismatches
    mode = 1;
    run(1'b0, 0);
    chk("m1_latency", edges, 41);
    chk("m1_mcnt", 32'(mcnt), 32'd10);
    chk("m1_pass", 32'(pass), 32'h0);
    chk("m1_ffv", 32'(ffv), 32'd0);
    chk("m1_ffs", 32'(ffs), 32'h1);
    chk("m1_pulses", pulses, 10);

    // Mismatch only on 4'hC
    mode = 2;
    run(1'b0, 0);
    chk("m2_mcnt", 32'(mcnt), 32'd1);
    chk("m2_ffv", 32'(ffv), 32'd3);
    chk("m2_ffs", 32'(ffs), 32'hC);
    chk("m2_pulses", pulses, 1);
    chk("m2_pass", 32'(pass), 32'h0);
    chk("m2_done", 32'(done), 32'h1);

    // Reset during SETTLE of vector 5
    mode = 0;
    run(1'b0, 22);
    chk("mid_busy", 32'(busy), 32'h1);
    chk("mid_stim", 32'(stim), 32'h7);
    chk("mid_vcnt", 32'(vcnt), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_flags", 32'({busy, done, pass, mpulse}), 32'h0);
    chk("mid_rst_cnt", 32'({vcnt, mcnt, ffv}), 32'h0);
    chk("mid_rst_stim", 32'({ffs, stim}), 32'h0);
    @(negedge clk);
    chk("idle_hold", 32'({busy, done}), 32'h0);
    run(1'b0, 0);
    chk("rerun_v0", 32'(seq[0]), 32'h1);
    chk("rerun_latency", edges, 41);
    chk("rerun_pass", 32'(pass), 32'h1);

    // start re-pulsed while busy, then restart from DONE
    mode = 2;
    run(1'b1, 0);
    chk("busy_start_latency", edges, 41);
    chk("busy_start_mcnt", 32'(mcnt), 32'd1);
    chk_seq("busy_start_stim");
    seq = '{default: 4'h0};
    run(1'b0, 0);
    chk("restart_latency", edges, 41);
    chk_seq("restart_stim");
    chk("restart_mcnt", 32'(mcnt), 32'd1);
    chk("restart_ffv", 32'(ffv), 32'd3);
    chk("restart_ffs", 32'(ffs), 32'hC);

    // SETTLE_CYCLES=1, N_VECTORS=1 instance
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    e = 0;
    s_pre = 4'hF;
    s_a = 4'hF;
    s_b = 4'hF;
    while (done1 !== 1'b1 && e < 50) begin
      @(negedge clk);
      e++;
      if (e == 1) s_pre = stim1;
      if (e == 2) s_a = stim1;
      if (e == 3) s_b = stim1;
    end
    chk("s1_latency", e, 4);
    chk("s1_pre", 32'(s_pre), 32'h0);
    chk("s1_settle", 32'(s_a), 32'h1);
    chk("s1_compare", 32'(s_b), 32'h1);
    chk("s1_pass", 32'(pass1), 32'h1);
    chk("s1_vcnt", 32'(vcnt1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
